// File: rtl/bus_host_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_host_arbiter_if
// Bundles the upstream host ports and the downstream device port of
// bus_host_arbiter. Signal suffixes (_i/_o) are from the arbiter's point of
// view.
//   modport slave  : arbiter side (takes host requests, drives the device)
//   modport master : environment side (hosts plus device model)
// Host-side fields are packed per host: [NrHosts-1:0][width-1:0].
// ---------------------------------------------------------------------------
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    // Host side
    logic [NrHosts-1:0]                      host_req_i;
    logic [NrHosts-1:0]                      host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i;
    logic [NrHosts-1:0]                      host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i;
    logic [NrHosts-1:0]                      host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o;
    logic [NrHosts-1:0]                      host_err_o;

    // Device side
    logic                                    dev_req_o;
    logic                                    dev_gnt_i;
    logic [AddressWidth-1:0]                 dev_addr_o;
    logic                                    dev_we_o;
    logic [DataWidth/8-1:0]                  dev_be_o;
    logic [DataWidth-1:0]                    dev_wdata_o;
    logic                                    dev_rvalid_i;
    logic [DataWidth-1:0]                    dev_rdata_i;
    logic                                    dev_err_i;

    // Status
    logic                                    unexpected_rsp_o;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output unexpected_rsp_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  unexpected_rsp_o
    );
endinterface

// File: rtl/bus_host_arbiter.sv
// ---------------------------------------------------------------------------
// bus_host_arbiter
// N-host to 1-device arbiter for a req/gnt/rvalid data bus. One host is
// selected per cycle; the grant is passed straight through from the device
// in the same cycle. The index of every granted host is queued in an
// in-order ID FIFO so that each device response is routed back to the host
// that issued the request, also with no added latency.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous reset, active-high
//   bus    - bus_host_arbiter_if.slave: host req/gnt/addr/we/be/wdata,
//            host rvalid/rdata/err, device req/gnt/addr/we/be/wdata,
//            device rvalid/rdata/err, unexpected_rsp_o pulse
//
// Build option:
//   BUS_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest host index
//   wins) replaces round-robin and the rotating pointer is removed. The ID
//   FIFO and response routing are the same in both builds.
// ---------------------------------------------------------------------------
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_host_arbiter_if.slave bus
);
    localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = DataWidth / 8;

    // -----------------------------------------------------------------------
    // Host selection
    // -----------------------------------------------------------------------
    logic [IdW-1:0]              start_ptr;
    logic [NrHosts-1:0][IdW-1:0] cand_idx;
    logic [IdW-1:0]              sel_idx;
    logic                        sel_valid;

`ifdef BUS_ARB_FIXED_PRIO_EN
    // Search always starts at host 0, so the lowest requesting index wins.
    assign start_ptr = '0;
`else
    logic [IdW-1:0] rr_ptr_reg;
    logic [IdW-1:0] rr_ptr_next;
    assign start_ptr = rr_ptr_reg;
`endif

    // cand_idx[k] is the host checked k-th in the search order, i.e.
    // (start_ptr + k) mod NrHosts. Written without '%' so that NrHosts need
    // not be a power of two and no divider is inferred.
    genvar gi;
    generate
        for (gi = 0; gi < NrHosts; gi++) begin : g_cand
            assign cand_idx[gi] = (int'(start_ptr) + gi < NrHosts)
                                ? IdW'(int'(start_ptr) + gi)
                                : IdW'(int'(start_ptr) + gi - NrHosts);
        end
    endgenerate

    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NrHosts; k++) begin
            if (!sel_valid && bus.host_req_i[cand_idx[k]]) begin
                sel_idx   = cand_idx[k];
                sel_valid = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // In-flight ID FIFO
    // -----------------------------------------------------------------------
    logic [IdW-1:0]  id_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntW-1:0] count_reg, count_next;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdW-1:0]  head_id;

    logic            dev_req;
    logic            grant;
    logic            push;
    logic            pop;

    assign fifo_full  = (count_reg == CntW'(MaxOutstanding));
    assign fifo_empty = (count_reg == '0);
    assign head_id    = id_mem[rd_ptr_reg];

    // Full is evaluated on the registered count: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign dev_req = sel_valid && !fifo_full && !rst_i;
    assign grant   = dev_req && bus.dev_gnt_i;
    assign push    = grant;
    assign pop     = bus.dev_rvalid_i && !fifo_empty && !rst_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= sel_idx;
        end
    end

`ifndef BUS_ARB_FIXED_PRIO_EN
    // -----------------------------------------------------------------------
    // Round-robin pointer: moves just past each grantee, so a host that keeps
    // requesting is reached within NrHosts grants.
    // -----------------------------------------------------------------------
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant) begin
            rr_ptr_next = (sel_idx == IdW'(NrHosts - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Device-side request mux
    // -----------------------------------------------------------------------
    logic [AddressWidth-1:0] sel_addr;
    logic [DataWidth-1:0]    sel_wdata;
    logic [BeW-1:0]          sel_be;
    logic                    sel_we;

    assign sel_addr  = sel_valid ? bus.host_addr_i[sel_idx]  : '0;
    assign sel_wdata = sel_valid ? bus.host_wdata_i[sel_idx] : '0;
    assign sel_be    = sel_valid ? bus.host_be_i[sel_idx]    : '0;
    assign sel_we    = sel_valid && bus.host_we_i[sel_idx];

    assign bus.dev_req_o   = dev_req;
    assign bus.dev_addr_o  = sel_addr;
    assign bus.dev_wdata_o = sel_wdata;
    assign bus.dev_be_o    = sel_be;
    assign bus.dev_we_o    = sel_we;

    // A response with nothing in flight (e.g. one issued before a reset) is
    // dropped and flagged instead of being routed.
    assign bus.unexpected_rsp_o = bus.dev_rvalid_i && fifo_empty && !rst_i;

    // -----------------------------------------------------------------------
    // Per-host grant and response routing
    // -----------------------------------------------------------------------
    logic [NrHosts-1:0] rsp_hit;

    generate
        for (gi = 0; gi < NrHosts; gi++) begin : g_host
            assign rsp_hit[gi]           = pop && (head_id == IdW'(gi));
            assign bus.host_gnt_o[gi]    = grant && (sel_idx == IdW'(gi));
            assign bus.host_rvalid_o[gi] = rsp_hit[gi];
            assign bus.host_rdata_o[gi]  = rsp_hit[gi] ? bus.dev_rdata_i : '0;
            assign bus.host_err_o[gi]    = rsp_hit[gi] && bus.dev_err_i;
        end
    endgenerate

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_host_arbiter_if #(.NrHosts(2), .DataWidth(32), .AddressWidth(32)) bus2 ();
    bus_host_arbiter_if #(.NrHosts(3), .DataWidth(32), .AddressWidth(32)) bus3 ();

    bus_host_arbiter #(.NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2.slave)
    );

    bus_host_arbiter #(.NrHosts(3), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3.slave)
    );

    typedef struct {
        int          owner;   // host expected to see rvalid, -1 for none
        logic [31:0] data;
        logic        err;
        logic        unexp;
    } rsp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   gnt_q[$];
    rsp_t rsp_q[$];
    int   owner2_q[$];
    int   owner3_q[$];

    function automatic logic [31:0] host_addr(input int h);
        return 32'h1000_0000 + 32'(h * 16);
    endfunction

    function automatic logic [31:0] host_wdata(input int h);
        return 32'hD000_0000 + 32'(h);
    endfunction

    // One clock of dut2: drive, queue expectations, compare at negedge.
    task automatic cycle2(input string tag, input logic r, input logic [1:0] req,
                          input logic rv, input logic [31:0] rd, input logic er, input int exp_g);
        rsp_t e;
        int g;
        logic [1:0] exp_gv, exp_rv, exp_ev;
        logic [1:0][31:0] exp_rd;
        rst = r;
        bus2.host_req_i   = req;
        bus2.dev_gnt_i    = 1'b1;
        bus2.dev_rvalid_i = rv;
        bus2.dev_rdata_i  = rd;
        bus2.dev_err_i    = er;
        e.owner = -1; e.data = rd; e.err = er; e.unexp = 1'b0;
        if (r) begin
            owner2_q.delete();
        end else begin
            if (rv) begin
                if (owner2_q.size() > 0) e.owner = owner2_q.pop_front();
                else e.unexp = 1'b1;
            end
            if (exp_g >= 0) owner2_q.push_back(exp_g);
        end
        rsp_q.push_back(e);
        gnt_q.push_back(r ? -1 : exp_g);
        @(negedge clk);
        g = gnt_q.pop_front();
        e = rsp_q.pop_front();
        exp_gv = '0; exp_rv = '0; exp_ev = '0; exp_rd = '0;
        if (g >= 0) exp_gv[g] = 1'b1;
        if (e.owner >= 0) begin
            exp_rv[e.owner] = 1'b1;
            exp_rd[e.owner] = e.data;
            exp_ev[e.owner] = e.err;
        end
        n_checks++;
        if (bus2.host_gnt_o !== exp_gv) begin
            n_errors++; $display("FAIL %s host_gnt_o: got %b want %b", tag, bus2.host_gnt_o, exp_gv);
        end
        n_checks++;
        if (bus2.dev_req_o !== (g >= 0)) begin
            n_errors++; $display("FAIL %s dev_req_o: got %b want %b", tag, bus2.dev_req_o, (g >= 0));
        end
        if (g >= 0) begin
            n_checks++;
            if (bus2.dev_addr_o !== host_addr(g) || bus2.dev_wdata_o !== host_wdata(g)) begin
                n_errors++; $display("FAIL %s dev_addr/wdata: got %h/%h want %h/%h", tag,
                                     bus2.dev_addr_o, bus2.dev_wdata_o, host_addr(g), host_wdata(g));
            end
        end
        n_checks++;
        if (bus2.host_rvalid_o !== exp_rv || bus2.host_rdata_o !== exp_rd || bus2.host_err_o !== exp_ev) begin
            n_errors++; $display("FAIL %s response: got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b", tag,
                                 bus2.host_rvalid_o, bus2.host_rdata_o, bus2.host_err_o, exp_rv, exp_rd, exp_ev);
        end
        n_checks++;
        if (bus2.unexpected_rsp_o !== e.unexp) begin
            n_errors++; $display("FAIL %s unexpected_rsp_o: got %b want %b", tag, bus2.unexpected_rsp_o, e.unexp);
        end
        $display("dut2 %s: gnt=%b rv=%b rdata=%h unexp=%b", tag, bus2.host_gnt_o, bus2.host_rvalid_o,
                 bus2.host_rdata_o, bus2.unexpected_rsp_o);
        @(posedge clk); #1;
    endtask

    // One clock of dut3 (three hosts), same scheme.
    task automatic cycle3(input string tag, input logic [2:0] req,
                          input logic rv, input logic [31:0] rd, input int exp_g);
        rsp_t e;
        int g;
        logic [2:0] exp_gv, exp_rv;
        logic [2:0][31:0] exp_rd;
        rst = 1'b0;
        bus3.host_req_i   = req;
        bus3.dev_gnt_i    = 1'b1;
        bus3.dev_rvalid_i = rv;
        bus3.dev_rdata_i  = rd;
        bus3.dev_err_i    = 1'b0;
        e.owner = -1; e.data = rd; e.err = 1'b0; e.unexp = 1'b0;
        if (rv) begin
            if (owner3_q.size() > 0) e.owner = owner3_q.pop_front();
            else e.unexp = 1'b1;
        end
        if (exp_g >= 0) owner3_q.push_back(exp_g);
        rsp_q.push_back(e);
        gnt_q.push_back(exp_g);
        @(negedge clk);
        g = gnt_q.pop_front();
        e = rsp_q.pop_front();
        exp_gv = '0; exp_rv = '0; exp_rd = '0;
        if (g >= 0) exp_gv[g] = 1'b1;
        if (e.owner >= 0) begin
            exp_rv[e.owner] = 1'b1;
            exp_rd[e.owner] = e.data;
        end
        n_checks++;
        if (bus3.host_gnt_o !== exp_gv) begin
            n_errors++; $display("FAIL %s host_gnt_o: got %b want %b", tag, bus3.host_gnt_o, exp_gv);
        end
        if (g >= 0) begin
            n_checks++;
            if (bus3.dev_addr_o !== host_addr(g)) begin
                n_errors++; $display("FAIL %s dev_addr_o: got %h want %h", tag, bus3.dev_addr_o, host_addr(g));
            end
        end
        n_checks++;
        if (bus3.host_rvalid_o !== exp_rv || bus3.host_rdata_o !== exp_rd || bus3.unexpected_rsp_o !== e.unexp) begin
            n_errors++; $display("FAIL %s response: got rv=%b rd=%h unexp=%b want rv=%b rd=%h unexp=%b", tag,
                                 bus3.host_rvalid_o, bus3.host_rdata_o, bus3.unexpected_rsp_o,
                                 exp_rv, exp_rd, e.unexp);
        end
        $display("dut3 %s: gnt=%b rv=%b rdata=%h", tag, bus3.host_gnt_o, bus3.host_rvalid_o, bus3.host_rdata_o);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus2.host_req_i = '0; bus2.dev_rvalid_i = 1'b0; bus2.dev_gnt_i = 1'b0;
        bus2.dev_rdata_i = '0; bus2.dev_err_i = 1'b0;
        bus3.host_req_i = '0; bus3.dev_rvalid_i = 1'b0; bus3.dev_gnt_i = 1'b0;
        bus3.dev_rdata_i = '0; bus3.dev_err_i = 1'b0;
    endtask

    task automatic test_reset();
        bus3.host_req_i = 3'b111; bus3.dev_gnt_i = 1'b1; bus3.dev_rvalid_i = 1'b1;
        cycle2("reset0", 1'b1, 2'b11, 1'b1, 32'h1111_1111, 1'b0, -1);
        cycle2("reset1", 1'b1, 2'b11, 1'b1, 32'h2222_2222, 1'b0, -1);
        // rst is still high here; dut3 must be silent too.
        n_checks++;
        if (bus3.host_gnt_o !== 3'b000 || bus3.host_rvalid_o !== 3'b000 ||
            bus3.dev_req_o !== 1'b0 || bus3.unexpected_rsp_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_dut3: got gnt=%b rv=%b req=%b unexp=%b want all 0",
                                 bus3.host_gnt_o, bus3.host_rvalid_o, bus3.dev_req_o, bus3.unexpected_rsp_o);
        end
        idle_inputs();
    endtask

    // Both hosts request every cycle; each response one cycle after its grant.
    task automatic test_round_robin();
        int exp_g;
        for (int k = 0; k < 4; k++) begin
            exp_g = FixedPrio ? 0 : (k % 2);
            cycle2($sformatf("rr%0d", k), 1'b0, 2'b11, (k > 0), 32'h0000_1000 + 32'(k), 1'b0, exp_g);
        end
        cycle2("rr_drain", 1'b0, 2'b00, 1'b1, 32'h0000_1004, 1'b0, -1);
        idle_inputs();
    endtask

    task automatic test_three_hosts();
        int exp_seq [5] = '{0, 2, 0, 1, 2};
        logic [2:0] req;
        for (int k = 0; k < 5; k++) begin
            req = (k == 3) ? 3'b111 : 3'b101;
            cycle3($sformatf("three%0d", k), req, (k > 0), 32'h0003_0000 + 32'(k),
                   FixedPrio ? 0 : exp_seq[k]);
        end
        cycle3("three_drain", 3'b000, 1'b1, 32'h0003_0005, -1);
        idle_inputs();
    endtask

    task automatic test_outstanding_limit();
        cycle2("lim0", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 0);
        cycle2("lim1", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, FixedPrio ? 0 : 1);
        cycle2("lim2_full", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, -1);
        cycle2("lim3_full", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, -1);
        cycle2("lim4_pop_full", 1'b0, 2'b11, 1'b1, 32'hA5A5_0001, 1'b0, -1);
        cycle2("lim5_third", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 0);
        cycle2("lim6_err", 1'b0, 2'b00, 1'b1, 32'hA5A5_0002, 1'b1, -1);
        cycle2("lim7", 1'b0, 2'b00, 1'b1, 32'hA5A5_0003, 1'b0, -1);
        idle_inputs();
    endtask

    task automatic test_unexpected_rsp();
        cycle2("unexp0", 1'b0, 2'b00, 1'b1, 32'hDEAD_0001, 1'b0, -1);
        cycle2("unexp1", 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, -1);
        idle_inputs();
    endtask

    // Two host-0 grants leave the round-robin pointer at 1; after reset the
    // next grant with both requesting must go to host 0 again.
    task automatic test_reset_mid_transaction();
        cycle2("mid0", 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        cycle2("mid1", 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        cycle2("mid_rst", 1'b1, 2'b11, 1'b1, 32'hBAD0_0000, 1'b0, -1);
        cycle2("mid_late0", 1'b0, 2'b00, 1'b1, 32'hBAD0_0001, 1'b0, -1);
        cycle2("mid_late1", 1'b0, 2'b00, 1'b1, 32'hBAD0_0002, 1'b0, -1);
        cycle2("mid_regrant", 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 0);
        cycle2("mid_rsp", 1'b0, 2'b00, 1'b1, 32'h0000_5A5A, 1'b0, -1);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        for (int h = 0; h < 2; h++) begin
            bus2.host_addr_i[h] = host_addr(h); bus2.host_wdata_i[h] = host_wdata(h);
            bus2.host_be_i[h] = 4'hF; bus2.host_we_i[h] = h[0];
        end
        for (int h = 0; h < 3; h++) begin
            bus3.host_addr_i[h] = host_addr(h); bus3.host_wdata_i[h] = host_wdata(h);
            bus3.host_be_i[h] = 4'hF; bus3.host_we_i[h] = h[0];
        end
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_three_hosts();
        test_round_robin();
        test_outstanding_limit();
        test_unexpected_rsp();
        test_reset_mid_transaction();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
